// File: rtl/core_spi_slave.sv
// SPI responder: oversamples CSB/SCLK/MOSI, shifts MOSI into a frame buffer and MISO out of a
// transmit buffer latched at chip-select fall; all CPOL/CPHA modes, optional 3-wire turnaround.
module core_spi_slave #(
  parameter int W_DAT = 32,
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [W_CNT-1:0] mosi_cnt,
  input  logic [W_DAT-1:0] dat_miso,
  output logic             f_start,
  output logic [W_DAT-1:0] dat_mosi,
  output logic [W_CNT-1:0] bit_rcv,
  output logic             f_rcv,
  output logic             miso_oe,
  input  logic             csb,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic csb_m_q, csb_s_q, csb_p_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic mosi_m_q, mosi_s_q;
  logic [1:0] warm_q, warm_d;

  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [W_CNT-1:0] mcnt_q, mcnt_d;
  logic [W_DAT-1:0] txd_q, txd_d;
  logic [W_DAT-1:0] rxd_q, rxd_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic             oe_q, oe_d;
  logic             miso_q, miso_d;
  logic             fin_q, fin_d;
  logic [W_DAT-1:0] dat_mosi_q, dat_mosi_d;
  logic [W_CNT-1:0] bit_rcv_q, bit_rcv_d;
  logic             f_rcv_q, f_rcv_d;
  logic             f_start_q, f_start_d;

  logic csb_fall, csb_rise, lead, trail;
  logic start_frame, end_frame, sample_en, shift_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_m_q  <= 1'b1;
      csb_s_q  <= 1'b1;
      csb_p_q  <= 1'b1;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
    end else begin
      csb_m_q  <= csb;
      csb_s_q  <= csb_m_q;
      csb_p_q  <= csb_s_q;
      sclk_m_q <= sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      mosi_m_q <= mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  assign csb_fall = csb_p_q & ~csb_s_q;
  assign csb_rise = ~csb_p_q & csb_s_q;
  assign lead     = (sclk_p_q == cpol_q) & (sclk_s_q != cpol_q);
  assign trail    = (sclk_p_q != cpol_q) & (sclk_s_q == cpol_q);

  // The synchronizers reset to "deselected"; wait until they carry real pin values so a
  // frame already running at reset release is not mistaken for idle.
  assign warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
      warm_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (warm_q == 2'd2 && csb_s_q) state_d = IDLE;
      IDLE:      if (csb_fall) state_d = ACTIVE;
      ACTIVE:    if (csb_rise) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    sample_en   = 1'b0;
    shift_edge  = 1'b0;
    case (state_q)
      IDLE:   start_frame = csb_fall;
      ACTIVE: begin
        end_frame  = csb_rise;
        sample_en  = ~csb_rise & (cpha_q ? trail : lead);
        shift_edge = ~csb_rise & (cpha_q ? lead : trail);
      end
      default: ;
    endcase
  end

  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    mcnt_d     = mcnt_q;
    txd_d      = txd_q;
    rxd_d      = rxd_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    oe_d       = oe_q;
    dat_mosi_d = dat_mosi_q;
    bit_rcv_d  = bit_rcv_q;
    f_start_d  = start_frame;
    fin_d      = end_frame;
    f_rcv_d    = fin_q;
    miso_d     = (state_q == ACTIVE) ? txd_q[W_DAT-1] : 1'b0;

    if (start_frame) begin
      cpol_d = cpol;
      cpha_d = cpha;
      mcnt_d = mosi_cnt;
      txd_d  = dat_miso;
      rxd_d  = '0;
      cnt_d  = '0;
      skip_d = cpha;
      oe_d   = &mosi_cnt;
    end else begin
      if (sample_en) begin
        rxd_d = {rxd_q[W_DAT-2:0], mosi_s_q};
        if (!(&cnt_q)) cnt_d = cnt_q + {{(W_CNT-1){1'b0}}, 1'b1};
      end
      // With CPHA=1 the first leading edge only marks the frame; MSB is already on the pin.
      if (shift_edge) begin
        skip_d = 1'b0;
        if (!skip_q) txd_d = txd_q << 1;
        if (cnt_q >= mcnt_q) oe_d = 1'b1;
      end
      if (end_frame) oe_d = 1'b0;
    end

    // Publishing one cycle after the state change lets a back-to-back frame clear rxd safely.
    if (fin_q) begin
      dat_mosi_d = rxd_q;
      bit_rcv_d  = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      mcnt_q     <= '0;
      txd_q      <= '0;
      rxd_q      <= '0;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      oe_q       <= 1'b0;
      miso_q     <= 1'b0;
      fin_q      <= 1'b0;
      dat_mosi_q <= '0;
      bit_rcv_q  <= '0;
      f_rcv_q    <= 1'b0;
      f_start_q  <= 1'b0;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      mcnt_q     <= mcnt_d;
      txd_q      <= txd_d;
      rxd_q      <= rxd_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      oe_q       <= oe_d;
      miso_q     <= miso_d;
      fin_q      <= fin_d;
      dat_mosi_q <= dat_mosi_d;
      bit_rcv_q  <= bit_rcv_d;
      f_rcv_q    <= f_rcv_d;
      f_start_q  <= f_start_d;
    end
  end

  assign f_start  = f_start_q;
  assign dat_mosi = dat_mosi_q;
  assign bit_rcv  = bit_rcv_q;
  assign f_rcv    = f_rcv_q;
  assign miso_oe  = oe_q;
  assign miso     = miso_q;

endmodule

// File: tb/tb_core_spi_slave.sv
// Bench for core_spi_slave: a bit-level SPI host drives frames, a frame-level model predicts
// received word, host read-back, bit count, output-enable pattern and pulse latencies.
module tb_core_spi_slave;
  localparam int W_DAT = 32;
  localparam int W_CNT = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [W_CNT-1:0] mosi_cnt = 8'hFF;
  logic [W_DAT-1:0] dat_miso = '0;
  logic             csb = 1'b1;
  logic             sclk = 1'b0;
  logic             host_bit = 1'b0;
  logic             host_oe = 1'b1;
  wire              f_start, f_rcv, miso_oe, miso, mosi_w;
  wire [W_DAT-1:0]  dat_mosi;
  wire [W_CNT-1:0]  bit_rcv;

  // Shared SDIO line in 3-wire use; weak low when nobody drives.
  assign mosi_w = host_oe ? host_bit : (miso_oe ? miso : 1'b0);

  core_spi_slave #(.W_DAT(W_DAT), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .mosi_cnt(mosi_cnt),
    .dat_miso(dat_miso), .f_start(f_start), .dat_mosi(dat_mosi), .bit_rcv(bit_rcv),
    .f_rcv(f_rcv), .miso_oe(miso_oe), .csb(csb), .sclk(sclk), .mosi(mosi_w), .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fs_cnt = 0, fs_cyc = 0, fr_cnt = 0, fr_cyc = 0;
  always @(negedge clk) begin
    if (f_start) begin fs_cnt++; fs_cyc = cyc; end
    if (f_rcv)   begin fr_cnt++; fr_cyc = cyc; end
  end

  int chk_cnt = 0, err_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          cur_n = 0, cur_hd = 0, half = 4, fall_cyc = 0, rise_cyc = 0;
  logic [63:0] cur_tx = '0, rd_v = '0, oe_v = '0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int i);
    if (i < cur_hd) host_bit = cur_tx[cur_n-1-i];
    else host_oe = 1'b0;
  endtask

  task automatic host_open();
    @(negedge clk);
    sclk = cpol; csb = 1'b1; host_oe = 1'b1; host_bit = 1'b0; rd_v = '0; oe_v = '0;
    wait_clk(8);
    csb = 1'b0; fall_cyc = cyc;
    if (!cpha && cur_n > 0) drive_bit(0);
    wait_clk(8);
  endtask

  task automatic host_clock(input int i);
    if (!cpha) begin
      rd_v[cur_n-1-i] = miso; oe_v[cur_n-1-i] = miso_oe;
      sclk = ~sclk; wait_clk(half);
      sclk = ~sclk; if (i + 1 < cur_n) drive_bit(i + 1);
      wait_clk(half);
    end else begin
      sclk = ~sclk; drive_bit(i); wait_clk(half);
      rd_v[cur_n-1-i] = miso; oe_v[cur_n-1-i] = miso_oe;
      sclk = ~sclk; wait_clk(half);
    end
  endtask

  task automatic host_close();
    wait_clk(8);
    csb = 1'b1; rise_cyc = cyc; host_oe = 1'b1; host_bit = 1'b0;
  endtask

  task automatic run_frame(input logic m_cpol, input logic m_cpha, input int n,
                           input logic [63:0] tx, input logic [31:0] dm,
                           input logic [7:0] mc, input int hp);
    int fs0, fr0, k;
    logic rb;
    logic [63:0] exp_rd, exp_oe;
    logic [31:0] exp_rx;
    cpol = m_cpol; cpha = m_cpha; dat_miso = dm; mosi_cnt = mc;
    cur_n = n; cur_tx = tx; half = hp;
    cur_hd = (mc == 8'hFF) ? n : int'(mc);
    fs0 = fs_cnt; fr0 = fr_cnt;
    host_open();
    for (int i = 0; i < n; i++) host_clock(i);
    host_close();
    k = 0;
    while (fr_cnt == fr0 && k < 20) begin wait_clk(1); k++; end

    // Host sees the MSB-first transmit word then zeros; DUT sees host bits, then the bus.
    exp_rd = '0; exp_oe = '0; exp_rx = '0;
    for (int i = 0; i < n; i++) begin
      rb = (i < 32) ? dm[31-i] : 1'b0;
      exp_rd[n-1-i] = rb;
      exp_oe[n-1-i] = (mc == 8'hFF) || (i >= int'(mc));
      exp_rx = {exp_rx[30:0], (i < cur_hd) ? tx[n-1-i] : rb};
    end
    chk("f_start_cnt", 64'(fs_cnt - fs0), 64'd1);
    chk("f_start_lat", 64'(fs_cyc - fall_cyc), 64'd3);
    chk("f_rcv_cnt", 64'(fr_cnt - fr0), 64'd1);
    chk("f_rcv_lat", 64'(fr_cyc - rise_cyc), 64'd4);
    chk("dat_mosi", 64'(dat_mosi), 64'(exp_rx));
    chk("bit_rcv", 64'(bit_rcv), 64'((n > 255) ? 255 : n));
    chk("host_rd", rd_v, exp_rd);
    chk("oe_at_sample", oe_v, exp_oe);
    chk("oe_after", 64'(miso_oe), 64'd0);
    wait_clk(5);
    chk("dat_mosi_hold", 64'(dat_mosi), 64'(exp_rx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int fs0, fr0;
    wait_clk(3);
    chk("reset_outputs", 64'({dat_mosi, bit_rcv, f_rcv, f_start, miso, miso_oe}), 64'd0);
    rst_n = 1'b1;
    wait_clk(4);

    run_frame(1'b0, 1'b0, 32, 64'hA5C3_0F96, 32'h1234_5678, 8'hFF, 4);
    run_frame(1'b0, 1'b1, 16, 64'hBEEF, 32'hCAFE_0000, 8'hFF, 4);
    run_frame(1'b1, 1'b0, 16, 64'hBEEF, 32'hCAFE_0000, 8'hFF, 4);
    run_frame(1'b1, 1'b1, 16, 64'hBEEF, 32'hCAFE_0000, 8'hFF, 4);
    run_frame(1'b0, 1'b0, 24, 64'h81_0000, 32'h00AB_CD00, 8'd8, 4);
    run_frame(1'b0, 1'b0, 40, {$urandom, $urandom}, $urandom, 8'hFF, 4);
    run_frame(1'b0, 1'b0, 0, 64'd0, $urandom, 8'hFF, 4);

    for (int r = 0; r < 12; r++)
      run_frame(1'($urandom), 1'($urandom), int'($urandom_range(1, 40)), {$urandom, $urandom},
                $urandom, 8'hFF, int'($urandom_range(4, 6)));

    // Reset in the middle of a frame, released while CSB is still low.
    cpol = 1'b0; cpha = 1'b0; mosi_cnt = 8'hFF; dat_miso = $urandom;
    cur_n = 16; cur_hd = 16; cur_tx = {32'd0, $urandom}; half = 4;
    host_open();
    for (int i = 0; i < 10; i++) host_clock(i);
    fs0 = fs_cnt; fr0 = fr_cnt;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_outputs", 64'({dat_mosi, bit_rcv, f_rcv, f_start, miso, miso_oe}), 64'd0);
    wait_clk(2);
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) host_clock(i);
    host_close();
    wait_clk(12);
    chk("rst_no_f_start", 64'(fs_cnt - fs0), 64'd0);
    chk("rst_no_f_rcv", 64'(fr_cnt - fr0), 64'd0);
    chk("rst_hold", 64'({dat_mosi, bit_rcv}), 64'd0);
    run_frame(1'b0, 1'b0, 32, {$urandom, $urandom}, $urandom, 8'hFF, 4);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end
endmodule
